// File: rtl/fragment_depth_writer_pkg.sv
// Shared types and constants for the fragment depth writer.
// FSM state encoding, the fragment record and the default pixel formats.
package fragment_pkg;

   localparam int FRAG_ADDR_WIDTH = 15;
   localparam int DEPTH_WIDTH     = 12;
   localparam int COLOR_WIDTH     = 4;
   localparam int DEPTH_CLEAR     = 4095;
   localparam int COLOR_CLEAR     = 0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_CLEAR = 2'd2,
      S_DONE  = 2'd3
   } fsm_state_e;

   typedef struct packed {
      logic [FRAG_ADDR_WIDTH-1:0] addr;
      logic [DEPTH_WIDTH-1:0]     depth;
      logic [COLOR_WIDTH-1:0]     color;
   } frag_t;

endpackage

// File: rtl/fragment_depth_writer_if.sv
// Fragment stream handshake between the rasterizer (master) and the
// depth writer (slave). Transfer happens when frag_valid && frag_ready.
interface fragment_depth_writer_if
   import fragment_pkg::*;
#(
   parameter int ADDR_W  = FRAG_ADDR_WIDTH,
   parameter int DEPTH_W = DEPTH_WIDTH,
   parameter int COLOR_W = COLOR_WIDTH
);
   logic               frag_valid;
   logic               frag_ready;
   logic [ADDR_W-1:0]  frag_addr;
   logic [DEPTH_W-1:0] frag_depth;
   logic [COLOR_W-1:0] frag_color;

   modport master (
      output frag_valid, frag_addr, frag_depth, frag_color,
      input  frag_ready
   );

   modport slave (
      input  frag_valid, frag_addr, frag_depth, frag_color,
      output frag_ready
   );
endinterface

// File: rtl/fragment_depth_writer_depth_bypass.sv
// Depth compare with forwarding of writes the depth memory has not yet
// made visible to the read port (W stage in flight, H committed last edge).
module depth_bypass
   import fragment_pkg::*;
#(
   parameter int ADDR_W  = FRAG_ADDR_WIDTH,
   parameter int DEPTH_W = DEPTH_WIDTH
) (
   input  logic [ADDR_W-1:0]  p1_addr_i,
   input  logic [DEPTH_W-1:0] p1_depth_i,
   input  logic               w_en_i,
   input  logic [ADDR_W-1:0]  w_addr_i,
   input  logic [DEPTH_W-1:0] w_depth_i,
   input  logic               h_vld_i,
   input  logic [ADDR_W-1:0]  h_addr_i,
   input  logic [DEPTH_W-1:0] h_depth_i,
   input  logic [DEPTH_W-1:0] rd_data_i,
   output logic [DEPTH_W-1:0] old_depth_o,
   output logic               pass_o
);
   // Newest write wins: W is younger than H, H is younger than memory.
   always_comb begin
      old_depth_o = rd_data_i;
      if (w_en_i && (w_addr_i == p1_addr_i)) begin
         old_depth_o = w_depth_i;
      end else if (h_vld_i && (h_addr_i == p1_addr_i)) begin
         old_depth_o = h_depth_i;
      end
      pass_o = (p1_depth_i < old_depth_o);
   end
endmodule

// File: rtl/fragment_depth_writer.sv
// Fragment depth writer: read-compare-write against the depth buffer with
// a two-cycle accept-to-write pipeline, plus the frame-clear sequencer.
// Optional pass/fail statistics counters: define FRAG_DEPTH_STATS_EN.
module fragment_depth_writer
   import fragment_pkg::*;
#(
   parameter int FB_WIDTH      = 160,
   parameter int FB_HEIGHT     = 120,
   parameter int FB_ADDR_WIDTH = $clog2(FB_WIDTH*FB_HEIGHT),
   parameter int COLOR_WIDTH   = 4,
   parameter int DEPTH_WIDTH   = 12,
   parameter int DEPTH_CLEAR   = 4095,
   parameter int COLOR_CLEAR   = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   fragment_depth_writer_if.slave   frag,
   input  logic                     clear_start,
   output logic                     clear_busy,
   output logic                     clear_done,
   output logic [FB_ADDR_WIDTH-1:0] db_rd_addr,
   input  logic [DEPTH_WIDTH-1:0]   db_rd_data,
   output logic                     db_wr_en,
   output logic [FB_ADDR_WIDTH-1:0] db_wr_addr,
   output logic [DEPTH_WIDTH-1:0]   db_wr_data,
   output logic                     fb_wr_en,
   output logic [FB_ADDR_WIDTH-1:0] fb_wr_addr,
   output logic [COLOR_WIDTH-1:0]   fb_wr_data,
   output logic [31:0]              frags_passed,
   output logic [31:0]              frags_failed
);
   localparam int NPIX = FB_WIDTH * FB_HEIGHT;
   localparam logic [FB_ADDR_WIDTH-1:0] LAST_ADDR = FB_ADDR_WIDTH'(NPIX - 1);

   fsm_state_e               state_q;
   logic [FB_ADDR_WIDTH-1:0] clr_cnt_q;

   logic                     accept;
   logic                     clear_accept;
   logic                     clearing;

   logic                     p1_vld_q, p1_vld_d;
   logic [FB_ADDR_WIDTH-1:0] p1_addr_q;
   logic [DEPTH_WIDTH-1:0]   p1_depth_q;
   logic [COLOR_WIDTH-1:0]   p1_color_q;

   logic                     w_en_q, w_en_d;
   logic [FB_ADDR_WIDTH-1:0] w_addr_q;
   logic [DEPTH_WIDTH-1:0]   w_depth_q;
   logic [COLOR_WIDTH-1:0]   w_color_q;

   logic                     h_vld_q, h_vld_d;
   logic [FB_ADDR_WIDTH-1:0] h_addr_q;
   logic [DEPTH_WIDTH-1:0]   h_depth_q;

   logic [DEPTH_WIDTH-1:0]   old_depth;
   logic                     pass;

   // A clear request in IDLE takes priority over any fragment offered with it.
   assign frag.frag_ready = (state_q == S_IDLE) && !clear_start;
   assign accept          = frag.frag_valid && frag.frag_ready;
   assign clear_accept    = (state_q == S_IDLE) && clear_start;
   assign clearing        = (state_q == S_CLEAR);

   assign p1_vld_d = accept;
   assign w_en_d   = p1_vld_q && pass;
   // H only describes the write that committed at the last edge; DONE drops it
   // because the clear has overwritten everything.
   assign h_vld_d  = w_en_q && (state_q != S_DONE);

   // Clear sequencer: drain the pipeline, sweep every address, pulse done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         clr_cnt_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (clear_start) state_q <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!p1_vld_q && !w_en_q) begin
                  state_q   <= S_CLEAR;
                  clr_cnt_q <= '0;
               end
            end
            S_CLEAR: begin
               if (clr_cnt_q == LAST_ADDR) state_q <= S_DONE;
               else                        clr_cnt_q <= clr_cnt_q + 1'b1;
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // P1: hold the accepted fragment while its depth read returns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p1_vld_q   <= 1'b0;
         p1_addr_q  <= '0;
         p1_depth_q <= '0;
         p1_color_q <= '0;
      end else begin
         p1_vld_q <= p1_vld_d;
         if (accept) begin
            p1_addr_q  <= frag.frag_addr;
            p1_depth_q <= frag.frag_depth;
            p1_color_q <= frag.frag_color;
         end
      end
   end

   // W: register the commit decision; drives the write ports for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_en_q    <= 1'b0;
         w_addr_q  <= '0;
         w_depth_q <= '0;
         w_color_q <= '0;
      end else begin
         w_en_q <= w_en_d;
         if (p1_vld_q) begin
            w_addr_q  <= p1_addr_q;
            w_depth_q <= p1_depth_q;
            w_color_q <= p1_color_q;
         end
      end
   end

   // H: remember the write that just landed, since a read issued at that
   // same edge saw the old contents (read-first memory).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_vld_q   <= 1'b0;
         h_addr_q  <= '0;
         h_depth_q <= '0;
      end else begin
         h_vld_q <= h_vld_d;
         if (w_en_q) begin
            h_addr_q  <= w_addr_q;
            h_depth_q <= w_depth_q;
         end
      end
   end

   depth_bypass #(
      .ADDR_W  (FB_ADDR_WIDTH),
      .DEPTH_W (DEPTH_WIDTH)
   ) u_bypass (
      .p1_addr_i   (p1_addr_q),
      .p1_depth_i  (p1_depth_q),
      .w_en_i      (w_en_q),
      .w_addr_i    (w_addr_q),
      .w_depth_i   (w_depth_q),
      .h_vld_i     (h_vld_q),
      .h_addr_i    (h_addr_q),
      .h_depth_i   (h_depth_q),
      .rd_data_i   (db_rd_data),
      .old_depth_o (old_depth),
      .pass_o      (pass)
   );

   assign db_rd_addr = frag.frag_addr;
   assign clear_busy = (state_q != S_IDLE);
   assign clear_done = (state_q == S_DONE);

   // The pipeline is empty whenever CLEAR runs, so the two write sources never overlap.
   assign db_wr_en   = clearing || w_en_q;
   assign fb_wr_en   = clearing || w_en_q;
   assign db_wr_addr = clearing ? clr_cnt_q : w_addr_q;
   assign fb_wr_addr = clearing ? clr_cnt_q : w_addr_q;
   assign db_wr_data = clearing ? DEPTH_WIDTH'(DEPTH_CLEAR) : w_depth_q;
   assign fb_wr_data = clearing ? COLOR_WIDTH'(COLOR_CLEAR) : w_color_q;

`ifdef FRAG_DEPTH_STATS_EN
   logic [31:0] passed_q, passed_d;
   logic [31:0] failed_q, failed_d;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   // Count each fragment once as it leaves P1; a new clear restarts the tally.
   always_comb begin
      passed_d = passed_q;
      failed_d = failed_q;
      if (clear_accept) begin
         passed_d = '0;
         failed_d = '0;
      end else if (p1_vld_q) begin
         if (pass) passed_d = sat_inc(passed_q);
         else      failed_d = sat_inc(failed_q);
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         passed_q <= '0;
         failed_q <= '0;
      end else begin
         passed_q <= passed_d;
         failed_q <= failed_d;
      end
   end

   assign frags_passed = passed_q;
   assign frags_failed = failed_q;
`else
   logic unused_stats;
   assign unused_stats = clear_accept ^ (|old_depth);
   assign frags_passed = '0;
   assign frags_failed = '0;
`endif

endmodule

// File: tb/tb_fragment_depth_writer.sv
// Directed bench for fragment_depth_writer with behavioural read-first
// depth and colour memories attached to the write/read ports.
module tb_fragment_depth_writer;
   import fragment_pkg::*;

   localparam int NPIX = 19200;
   localparam int NV   = 16;

   logic        clk;
   logic        rst_n;
   logic        clear_start;
   logic        clear_busy, clear_done;
   logic [14:0] db_rd_addr;
   logic [11:0] db_rd_data;
   logic        db_wr_en, fb_wr_en;
   logic [14:0] db_wr_addr, fb_wr_addr;
   logic [11:0] db_wr_data;
   logic [3:0]  fb_wr_data;
   logic [31:0] frags_passed, frags_failed;

   fragment_depth_writer_if #(.ADDR_W(15), .DEPTH_W(12), .COLOR_W(4)) fif ();

   fragment_depth_writer dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .frag         (fif.slave),
      .clear_start  (clear_start),
      .clear_busy   (clear_busy),
      .clear_done   (clear_done),
      .db_rd_addr   (db_rd_addr),
      .db_rd_data   (db_rd_data),
      .db_wr_en     (db_wr_en),
      .db_wr_addr   (db_wr_addr),
      .db_wr_data   (db_wr_data),
      .fb_wr_en     (fb_wr_en),
      .fb_wr_addr   (fb_wr_addr),
      .fb_wr_data   (fb_wr_data),
      .frags_passed (frags_passed),
      .frags_failed (frags_failed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Read-first synchronous memories.
   logic [11:0] dmem [0:NPIX-1];
   logic [3:0]  cmem [0:NPIX-1];
   always @(posedge clk) begin
      db_rd_data <= (db_rd_addr < 15'(NPIX)) ? dmem[db_rd_addr] : 12'd0;
      if (db_wr_en && db_wr_addr < 15'(NPIX)) dmem[db_wr_addr] <= db_wr_data;
      if (fb_wr_en && fb_wr_addr < 15'(NPIX)) cmem[fb_wr_addr] <= fb_wr_data;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   typedef struct {
      logic        vld;
      logic [14:0] addr;
      logic [11:0] depth;
      logic [3:0]  color;
      logic        exp_wr;
   } vec_t;

   vec_t vecs [NV];

   initial begin : watchdog
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      int nwr, bad, rdy_busy, dones, cyc;
      logic [14:0] first_addr, second_addr;
      logic [11:0] first_depth, second_depth;
      logic [3:0]  first_color;
      logic        seen;

      rst_n = 1'b0;
      clear_start = 1'b0;
      fif.frag_valid = 1'b0;
      fif.frag_addr  = '0;
      fif.frag_depth = '0;
      fif.frag_color = '0;
      for (int k = 0; k < NPIX; k++) begin
         dmem[k] = 12'd0;
         cmem[k] = 4'd0;
      end

      // ---------------- reset state
      #23;
      check("reset_db_wr_en", {31'd0, db_wr_en}, 32'd0);
      check("reset_fb_wr_en", {31'd0, fb_wr_en}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      check("reset_ready", {31'd0, fif.frag_ready}, 32'd1);
      check("reset_busy", {31'd0, clear_busy}, 32'd0);
      check("reset_done", {31'd0, clear_done}, 32'd0);
      check("reset_passed", frags_passed, 32'd0);
      check("reset_failed", frags_failed, 32'd0);

      // ---------------- full clear after reset
      @(negedge clk);
      clear_start = 1'b1;
      #1;
      check("clear_req_ready_low", {31'd0, fif.frag_ready}, 32'd0);
      nwr = 0; bad = 0; rdy_busy = 0; dones = 0; seen = 1'b0;
      for (cyc = 0; cyc < 20000 && !seen; cyc++) begin
         @(negedge clk);
         clear_start = 1'b0;
         #1;
         if (fif.frag_ready) rdy_busy++;
         if (db_wr_en || fb_wr_en) begin
            if (!(db_wr_en && fb_wr_en && db_wr_addr == 15'(nwr) && fb_wr_addr == 15'(nwr)
                  && db_wr_data == 12'd4095 && fb_wr_data == 4'd0)) bad++;
            nwr++;
         end
         if (clear_done) begin
            dones++;
            seen = 1'b1;
         end
      end
      check("clear_timeout", {31'd0, seen}, 32'd1);
      check("clear_write_count", nwr, NPIX);
      check("clear_write_content", bad, 0);
      check("clear_ready_during_busy", rdy_busy, 0);
      check("clear_done_pulses", dones, 1);
      @(negedge clk);
      #1;
      check("clear_done_one_cycle", {31'd0, clear_done}, 32'd0);
      check("clear_busy_after", {31'd0, clear_busy}, 32'd0);
      check("clear_ready_after", {31'd0, fif.frag_ready}, 32'd1);
      check("clear_stats_passed", frags_passed, 32'd0);

      // ---------------- fragment stream table
      vecs[0]  = '{1'b1, 15'd100, 12'd500,  4'd7,  1'b1};
      vecs[1]  = '{1'b0, 15'd0,   12'd0,    4'd0,  1'b0};
      vecs[2]  = '{1'b0, 15'd0,   12'd0,    4'd0,  1'b0};
      vecs[3]  = '{1'b1, 15'd200, 12'd800,  4'd1,  1'b1};
      vecs[4]  = '{1'b1, 15'd200, 12'd900,  4'd2,  1'b0};
      vecs[5]  = '{1'b1, 15'd200, 12'd300,  4'd3,  1'b1};
      vecs[6]  = '{1'b0, 15'd0,   12'd0,    4'd0,  1'b0};
      vecs[7]  = '{1'b1, 15'd300, 12'd600,  4'd4,  1'b1};
      vecs[8]  = '{1'b0, 15'd0,   12'd0,    4'd0,  1'b0};
      vecs[9]  = '{1'b1, 15'd300, 12'd600,  4'd5,  1'b0};
      vecs[10] = '{1'b1, 15'd400, 12'd4095, 4'd6,  1'b0};
      vecs[11] = '{1'b1, 15'd401, 12'd4094, 4'd8,  1'b1};
      vecs[12] = '{1'b1, 15'd100, 12'd600,  4'd9,  1'b0};
      vecs[13] = '{1'b1, 15'd100, 12'd499,  4'd10, 1'b1};
      vecs[14] = '{1'b0, 15'd0,   12'd0,    4'd0,  1'b0};
      vecs[15] = '{1'b0, 15'd0,   12'd0,    4'd0,  1'b0};

      for (int i = 0; i < NV + 2; i++) begin
         @(negedge clk);
         if (i < NV) begin
            fif.frag_valid = vecs[i].vld;
            fif.frag_addr  = vecs[i].addr;
            fif.frag_depth = vecs[i].depth;
            fif.frag_color = vecs[i].color;
         end else begin
            fif.frag_valid = 1'b0;
         end
         #1;
         if (i < NV && vecs[i].vld)
            check($sformatf("tbl%0d_ready", i), {31'd0, fif.frag_ready}, 32'd1);
         if (i >= 2) begin
            check($sformatf("tbl%0d_db_wr_en", i - 2), {31'd0, db_wr_en}, {31'd0, vecs[i-2].exp_wr});
            check($sformatf("tbl%0d_fb_wr_en", i - 2), {31'd0, fb_wr_en}, {31'd0, vecs[i-2].exp_wr});
            if (vecs[i-2].exp_wr) begin
               check($sformatf("tbl%0d_addr", i - 2), {17'd0, db_wr_addr}, {17'd0, vecs[i-2].addr});
               check($sformatf("tbl%0d_depth", i - 2), {20'd0, db_wr_data}, {20'd0, vecs[i-2].depth});
               check($sformatf("tbl%0d_color", i - 2), {28'd0, fb_wr_data}, {28'd0, vecs[i-2].color});
            end
         end
      end
      fif.frag_valid = 1'b0;
      @(negedge clk);
      check("mem_depth_200", {20'd0, dmem[200]}, 32'd300);
      check("mem_color_200", {28'd0, cmem[200]}, 32'd3);
      check("mem_depth_300", {20'd0, dmem[300]}, 32'd600);
      check("mem_color_300", {28'd0, cmem[300]}, 32'd4);
      check("mem_depth_100", {20'd0, dmem[100]}, 32'd499);
      check("mem_color_100", {28'd0, cmem[100]}, 32'd10);
      check("mem_depth_400", {20'd0, dmem[400]}, 32'd4095);
`ifdef FRAG_DEPTH_STATS_EN
      check("stats_passed", frags_passed, 32'd6);
      check("stats_failed", frags_failed, 32'd4);
`else
      check("stats_passed_tied", frags_passed, 32'd0);
      check("stats_failed_tied", frags_failed, 32'd0);
`endif

      // ---------------- clear with a fragment in flight
      @(negedge clk);
      fif.frag_valid = 1'b1;
      fif.frag_addr  = 15'd500;
      fif.frag_depth = 12'd100;
      fif.frag_color = 4'd11;
      @(negedge clk);
      fif.frag_addr  = 15'd501;
      fif.frag_color = 4'd12;
      clear_start = 1'b1;
      #1;
      check("inflight_ready_with_clear", {31'd0, fif.frag_ready}, 32'd0);
      nwr = 0; rdy_busy = 0; seen = 1'b0;
      first_addr = '0; first_depth = '0; first_color = '0;
      second_addr = 15'h7fff; second_depth = '0;
      for (cyc = 0; cyc < 20000 && !seen; cyc++) begin
         @(negedge clk);
         clear_start = 1'b0;
         #1;
         if (fif.frag_ready) rdy_busy++;
         if (db_wr_en) begin
            if (nwr == 0) begin
               first_addr = db_wr_addr; first_depth = db_wr_data; first_color = fb_wr_data;
            end else if (nwr == 1) begin
               second_addr = db_wr_addr; second_depth = db_wr_data;
            end
            nwr++;
         end
         if (clear_done) begin
            seen = 1'b1;
            fif.frag_valid = 1'b0;
         end
      end
      check("inflight_timeout", {31'd0, seen}, 32'd1);
      check("inflight_first_addr", {17'd0, first_addr}, 32'd500);
      check("inflight_first_depth", {20'd0, first_depth}, 32'd100);
      check("inflight_first_color", {28'd0, first_color}, 32'd11);
      check("inflight_second_addr", {17'd0, second_addr}, 32'd0);
      check("inflight_second_depth", {20'd0, second_depth}, 32'd4095);
      check("inflight_write_count", nwr, NPIX + 1);
      check("inflight_ready_busy", rdy_busy, 0);
      @(negedge clk);
      check("inflight_mem_500", {20'd0, dmem[500]}, 32'd4095);
      check("inflight_mem_501", {20'd0, dmem[501]}, 32'd4095);

      // ---------------- reset in the middle of a clear
      @(negedge clk);
      fif.frag_valid = 1'b1;
      fif.frag_addr  = 15'd700;
      fif.frag_depth = 12'd10;
      @(negedge clk);
      fif.frag_valid = 1'b0;
      clear_start = 1'b1;
      @(negedge clk);
      clear_start = 1'b0;
      seen = 1'b0;
      for (cyc = 0; cyc < 6000 && !seen; cyc++) begin
         @(negedge clk);
         #1;
         if (db_wr_en && db_wr_addr == 15'd5000) seen = 1'b1;
      end
      check("midclear_reach_5000", {31'd0, seen}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midclear_db_wr_en", {31'd0, db_wr_en}, 32'd0);
      check("midclear_fb_wr_en", {31'd0, fb_wr_en}, 32'd0);
      check("midclear_busy", {31'd0, clear_busy}, 32'd0);
      check("midclear_passed", frags_passed, 32'd0);
      check("midclear_failed", frags_failed, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      check("postreset_no_write", {31'd0, db_wr_en}, 32'd0);
      check("postreset_busy", {31'd0, clear_busy}, 32'd0);
      check("postreset_ready", {31'd0, fif.frag_ready}, 32'd1);
      check("postreset_mem_5001", {20'd0, dmem[5001]}, 32'd4095);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
